e203_exu_oitf_trk: RTL and testbench
====================================

// Module: e203_exu_oitf_trk
// PURPOSE
//  Outstanding Instruction Track FIFO for long-pipe ops (LSU loads/stores, NICE).
//  Dispatch allocates one entry per long-pipe instr and hands its index out as the itag.
//  The long-pipe writeback stage retires entries in order, using ret_ptr and ret_* fields to match itags.
//  Also flags RAW/WAW hazards between the dispatching instr and in-flight entries.
// PARAMETERS
//  DEPTH  2   entry count; power of 2, >=2; PTR_W = log2(DEPTH) (1 at default = itag width)
// PORTS
//  clk                 in   1      clock, all state on rising edge
//  rst                 in   1      asynchronous reset, active-high
//  dis_ena             in   1      allocate entry this cycle (honoured only when dis_ready=1)
//  dis_ready           out  1      = ~oitf_full
//  dis_ptr             out  PTR_W  index the entry is allocated at (the instr's itag)
//  dis_rdidx           in   5      dest reg of dispatching instr
//  dis_rdwen           in   1      dispatching instr writes a reg
//  dis_rdfpu           in   1      dest is FPU reg file
//  dis_pc              in   32     PC of dispatching instr
//  dis_rs1idx/rs2idx/rs3idx in 5   source regs of dispatching instr (hazard check)
//  dis_rs1en/rs2en/rs3en    in 1   source valid
//  dis_rs1fpu/rs2fpu/rs3fpu in 1   source is FPU reg
//  ret_ena             in   1      retire entry at ret_ptr (ignored when empty)
//  oitf_empty          out  1      no valid entries
//  oitf_full           out  1      all DEPTH entries valid
//  oitf_ret_ptr        out  PTR_W  oldest entry index
//  oitf_ret_rdidx      out  5      rdidx of oldest entry
//  oitf_ret_pc         out  32     pc of oldest entry
//  oitf_ret_rdwen      out  1      rdwen of oldest entry
//  oitf_ret_rdfpu      out  1      rdfpu of oldest entry
//  oitfrd_match_disprs1/rs2/rs3 out 1  source matches a valid entry's dest (RAW)
//  oitfrd_match_disprd out  1      dis_rdidx matches a valid entry's dest (WAW)
// BEHAVIOUR
//  - Reset (async, rst=1): wr_ptr=0, rd_ptr=0, both wrap flags=0, all valid=0, entry data=0.
//    Hence oitf_empty=1, oitf_full=0, dis_ready=1, dis_ptr=0, ret_ptr=0, ret_* =0, all match=0.
//  - Pointers: PTR_W index + 1 wrap flag each. Flag toggles when the index wraps DEPTH-1 -> 0.
//  - Empty: (wr==rd) and flags equal. Full: (wr==rd) and flags differ.
//  - dis_fire = dis_ena & dis_ready. On dis_fire the entry at wr_ptr is written with
//    {rdidx,rdwen,rdfpu,pc}, valid set, wr_ptr advances; visible next cycle.
//  - ret_fire = ret_ena & ~oitf_empty. On ret_fire the entry at rd_ptr is cleared, rd_ptr advances.
//  - dis_ready depends only on registered full; dispatch while full is rejected even if ret_fire
//    occurs in the same cycle (no combinational ret->dis path).
//  - Simultaneous dis_fire and ret_fire, non-empty and non-full: both take effect, count unchanged.
//  - Simultaneous when empty: dis accepted, ret ignored; next cycle empty=0.
//  - dis_ena while full, or ret_ena while empty: no state change.
//  - ret_* outputs: combinational read of the entry at rd_ptr; 0-latency, valid only when ~empty.
//  - Hazard match: OR over entries e with valid[e] & rdwen[e]:
//    rsN: dis_rsNen & (rdidx[e]==dis_rsNidx) & (rdfpu[e]==dis_rsNfpu);
//    rd : dis_rdwen & (rdidx[e]==dis_rdidx) & (rdfpu[e]==dis_rdfpu).
//    Combinational, uses current (pre-edge) state; an entry retiring this cycle still matches.
//  - x0 not special-cased here (the dispatch stage masks it).
//  - rst asserted mid-operation: all in-flight entries are discarded immediately;
//    no retire or match is reported afterwards.
// TESTING
//  T1 reset: rst=1 then 0 -> empty=1, full=0, dis_ready=1, ret_ptr=0, all matches 0.
//  T2 fill: dis_ena=1 with rdidx=5 then rdidx=7 on 2 cycles, DEPTH=2 -> dis_ptr 0 then 1;
//     full=1, dis_ready=0; a third dis_ena is ignored (wr_ptr holds).
//  T3 retire order: from T2, ret_ena x2 -> ret_rdidx 5 then 7, ret_ptr 0 then 1; then empty=1.
//     ret_ena again -> no change.
//  T4 wrap: 6 alternating dis/ret pairs -> dis_ptr sequence 0,1,0,1,0,1; never full; pc returned intact.
//  T5 hazard: entry rdidx=3, rdwen=1, rdfpu=0; dis_rs1idx=3, rs1en=1 -> match_disprs1=1.
//     Same with rs1fpu=1 or rdwen=0 -> 0. dis_rdidx=3 -> match_disprd=1.
//  T6 simultaneity/reset: dis+ret with 1 entry valid -> count stays 1.
//     rst pulse mid-stream with full=1 -> empty=1 the same cycle; random dis/ret
//     run vs a queue model for >=5000 cycles.

Source files
------------

// File: rtl/e203_exu_oitf_trk.sv
// Outstanding instruction track FIFO for long-pipe ops: allocates itags at
// dispatch, retires in order at writeback and flags RAW/WAW hazards.
module e203_exu_oitf_trk #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dis_ena,
    output logic             dis_ready,
    output logic [PTR_W-1:0] dis_ptr,
    input  logic [4:0]       dis_rdidx,
    input  logic             dis_rdwen,
    input  logic             dis_rdfpu,
    input  logic [31:0]      dis_pc,
    input  logic [4:0]       dis_rs1idx,
    input  logic [4:0]       dis_rs2idx,
    input  logic [4:0]       dis_rs3idx,
    input  logic             dis_rs1en,
    input  logic             dis_rs2en,
    input  logic             dis_rs3en,
    input  logic             dis_rs1fpu,
    input  logic             dis_rs2fpu,
    input  logic             dis_rs3fpu,
    input  logic             ret_ena,
    output logic             oitf_empty,
    output logic             oitf_full,
    output logic [PTR_W-1:0] oitf_ret_ptr,
    output logic [4:0]       oitf_ret_rdidx,
    output logic [31:0]      oitf_ret_pc,
    output logic             oitf_ret_rdwen,
    output logic             oitf_ret_rdfpu,
    output logic             oitfrd_match_disprs1,
    output logic             oitfrd_match_disprs2,
    output logic             oitfrd_match_disprs3,
    output logic             oitfrd_match_disprd
);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_flg, rd_flg;
    logic             vld   [DEPTH];
    logic [4:0]       rdidx [DEPTH];
    logic             rdwen [DEPTH];
    logic             rdfpu [DEPTH];
    logic [31:0]      pc    [DEPTH];

    logic dis_fire, ret_fire;

    assign oitf_empty = (wr_ptr == rd_ptr) && (wr_flg == rd_flg);
    assign oitf_full  = (wr_ptr == rd_ptr) && (wr_flg != rd_flg);
    // Readiness comes from registered state only, so a same-cycle retire never frees a slot.
    assign dis_ready  = ~oitf_full;
    assign dis_fire   = dis_ena & dis_ready;
    assign ret_fire   = ret_ena & ~oitf_empty;
    assign dis_ptr    = wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_flg <= 1'b0;
            rd_flg <= 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                vld[e]   <= 1'b0;
                rdidx[e] <= '0;
                rdwen[e] <= 1'b0;
                rdfpu[e] <= 1'b0;
                pc[e]    <= '0;
            end
        end else begin
            // Retired entries are zeroed so the ret_* outputs read 0 while empty.
            if (ret_fire) begin
                vld[rd_ptr]   <= 1'b0;
                rdidx[rd_ptr] <= '0;
                rdwen[rd_ptr] <= 1'b0;
                rdfpu[rd_ptr] <= 1'b0;
                pc[rd_ptr]    <= '0;
                if (rd_ptr == PTR_W'(DEPTH - 1)) begin
                    rd_ptr <= '0;
                    rd_flg <= ~rd_flg;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            if (dis_fire) begin
                vld[wr_ptr]   <= 1'b1;
                rdidx[wr_ptr] <= dis_rdidx;
                rdwen[wr_ptr] <= dis_rdwen;
                rdfpu[wr_ptr] <= dis_rdfpu;
                pc[wr_ptr]    <= dis_pc;
                if (wr_ptr == PTR_W'(DEPTH - 1)) begin
                    wr_ptr <= '0;
                    wr_flg <= ~wr_flg;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    assign oitf_ret_ptr   = rd_ptr;
    assign oitf_ret_rdidx = rdidx[rd_ptr];
    assign oitf_ret_pc    = pc[rd_ptr];
    assign oitf_ret_rdwen = rdwen[rd_ptr];
    assign oitf_ret_rdfpu = rdfpu[rd_ptr];

    // Hazards use pre-edge state, so an entry retiring this cycle still matches.
    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprs3 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            if (vld[e] && rdwen[e]) begin
                oitfrd_match_disprs1 |= dis_rs1en & (rdidx[e] == dis_rs1idx) & (rdfpu[e] == dis_rs1fpu);
                oitfrd_match_disprs2 |= dis_rs2en & (rdidx[e] == dis_rs2idx) & (rdfpu[e] == dis_rs2fpu);
                oitfrd_match_disprs3 |= dis_rs3en & (rdidx[e] == dis_rs3idx) & (rdfpu[e] == dis_rs3fpu);
                oitfrd_match_disprd  |= dis_rdwen & (rdidx[e] == dis_rdidx)  & (rdfpu[e] == dis_rdfpu);
            end
        end
    end

endmodule

// File: tb/tb_e203_exu_oitf_trk.sv
// Bench for e203_exu_oitf_trk: directed vectors plus a random run, with a
// queue scoreboard popped by a negedge monitor on every retire.
module tb_e203_exu_oitf_trk;
    localparam int DEPTH = 2;
    localparam int PTR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dis_ena = 0, ret_ena = 0;
    logic [4:0] dis_rdidx = 0;
    logic dis_rdwen = 0, dis_rdfpu = 0;
    logic [31:0] dis_pc = 0;
    logic [4:0] dis_rs1idx = 0, dis_rs2idx = 0, dis_rs3idx = 0;
    logic dis_rs1en = 0, dis_rs2en = 0, dis_rs3en = 0;
    logic dis_rs1fpu = 0, dis_rs2fpu = 0, dis_rs3fpu = 0;
    logic dis_ready, oitf_empty, oitf_full;
    logic [PTR_W-1:0] dis_ptr, oitf_ret_ptr;
    logic [4:0] oitf_ret_rdidx;
    logic [31:0] oitf_ret_pc;
    logic oitf_ret_rdwen, oitf_ret_rdfpu;
    logic m_rs1, m_rs2, m_rs3, m_rd;

    e203_exu_oitf_trk #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
        .dis_rdidx(dis_rdidx), .dis_rdwen(dis_rdwen), .dis_rdfpu(dis_rdfpu), .dis_pc(dis_pc),
        .dis_rs1idx(dis_rs1idx), .dis_rs2idx(dis_rs2idx), .dis_rs3idx(dis_rs3idx),
        .dis_rs1en(dis_rs1en), .dis_rs2en(dis_rs2en), .dis_rs3en(dis_rs3en),
        .dis_rs1fpu(dis_rs1fpu), .dis_rs2fpu(dis_rs2fpu), .dis_rs3fpu(dis_rs3fpu),
        .ret_ena(ret_ena), .oitf_empty(oitf_empty), .oitf_full(oitf_full),
        .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_ret_pc(oitf_ret_pc),
        .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdfpu(oitf_ret_rdfpu),
        .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
        .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ptr;
        int rdidx;
        int rdwen;
        int rdfpu;
        int pc;
    } ent_t;

    ent_t q[$];
    ent_t pend;
    bit   acc_pend = 0;
    int   mwr = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: flag/hazard checks against the queue model, and pop on every retire.
    always @(negedge clk) begin
        int h1, h2, h3, hd;
        ent_t x;
        if (!rst) begin
            chk("empty", int'(oitf_empty), int'(q.size() == 0));
            chk("full", int'(oitf_full), int'(q.size() == DEPTH));
            chk("dis_ready", int'(dis_ready), int'(q.size() != DEPTH));
            chk("dis_ptr", int'(dis_ptr), mwr);
            h1 = 0; h2 = 0; h3 = 0; hd = 0;
            foreach (q[i]) begin
                if (q[i].rdwen != 0) begin
                    if (dis_rs1en && q[i].rdidx == int'(dis_rs1idx) && q[i].rdfpu == int'(dis_rs1fpu)) h1 = 1;
                    if (dis_rs2en && q[i].rdidx == int'(dis_rs2idx) && q[i].rdfpu == int'(dis_rs2fpu)) h2 = 1;
                    if (dis_rs3en && q[i].rdidx == int'(dis_rs3idx) && q[i].rdfpu == int'(dis_rs3fpu)) h3 = 1;
                    if (dis_rdwen && q[i].rdidx == int'(dis_rdidx) && q[i].rdfpu == int'(dis_rdfpu)) hd = 1;
                end
            end
            chk("match_rs1", int'(m_rs1), h1);
            chk("match_rs2", int'(m_rs2), h2);
            chk("match_rs3", int'(m_rs3), h3);
            chk("match_rd", int'(m_rd), hd);
            if (q.size() == 0) begin
                chk("idle_ret_pc", int'(oitf_ret_pc), 0);
                chk("idle_ret_rdidx", int'(oitf_ret_rdidx), 0);
            end
            if (ret_ena && q.size() > 0) begin
                x = q.pop_front();
                chk("ret_ptr", int'(oitf_ret_ptr), x.ptr);
                chk("ret_rdidx", int'(oitf_ret_rdidx), x.rdidx);
                chk("ret_pc", int'(oitf_ret_pc), x.pc);
                chk("ret_rdwen", int'(oitf_ret_rdwen), x.rdwen);
                chk("ret_rdfpu", int'(oitf_ret_rdfpu), x.rdfpu);
            end
        end
    end

    task automatic set_src(input int i1, input bit e1, input bit f1,
                           input int i2, input bit e2, input bit f2,
                           input int i3, input bit e3, input bit f3);
        dis_rs1idx = 5'(i1); dis_rs1en = e1; dis_rs1fpu = f1;
        dis_rs2idx = 5'(i2); dis_rs2en = e2; dis_rs2fpu = f2;
        dis_rs3idx = 5'(i3); dis_rs3en = e3; dis_rs3fpu = f3;
    endtask

    // Drive one cycle of inputs (called just after a rising edge) and stop past the monitor.
    task automatic drive(input bit d, input bit r, input int idx, input bit wen, input bit fpu, input int pcv);
        dis_ena = d; ret_ena = r;
        dis_rdidx = 5'(idx); dis_rdwen = wen; dis_rdfpu = fpu; dis_pc = 32'(pcv);
        acc_pend = d && (q.size() < DEPTH);
        pend = '{mwr, idx, int'(wen), int'(fpu), pcv};
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (acc_pend) begin
            q.push_back(pend);
            mwr = (mwr + 1) % DEPTH;
        end
        acc_pend = 0;
        #1;
    endtask

    task automatic rst_pulse();
        dis_ena = 0; ret_ena = 0; dis_rdwen = 0;
        rst = 1'b1;
        q.delete();
        mwr = 0;
        acc_pend = 0;
        #1;
        chk("rst_empty", int'(oitf_empty), 1);
        chk("rst_full", int'(oitf_full), 0);
        chk("rst_dis_ready", int'(dis_ready), 1);
        chk("rst_ret_ptr", int'(oitf_ret_ptr), 0);
        chk("rst_ret_pc", int'(oitf_ret_pc), 0);
        chk("rst_match_rs1", int'(m_rs1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_src(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        // T1 reset
        rst_pulse();
        chk("t1_dis_ptr", int'(dis_ptr), 0);
        chk("t1_match_rd", int'(m_rd), 0);

        // T2 fill, then a rejected dispatch while full
        drive(1, 0, 5, 1, 0, 32'h100); chk("t2_ptr0", int'(dis_ptr), 0); tick();
        drive(1, 0, 7, 1, 0, 32'h104); chk("t2_ptr1", int'(dis_ptr), 1); tick();
        drive(1, 0, 9, 1, 0, 32'h108);
        chk("t2_full", int'(oitf_full), 1); chk("t2_ready", int'(dis_ready), 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_wr_hold", int'(dis_ptr), 0); chk("t2_still_full", int'(oitf_full), 1);
        chk("t2_head", int'(oitf_ret_rdidx), 5); tick();

        // T3 in-order retire, then retire while empty
        drive(0, 1, 0, 0, 0, 0); chk("t3_rd0", int'(oitf_ret_rdidx), 5); chk("t3_p0", int'(oitf_ret_ptr), 0); tick();
        drive(0, 1, 0, 0, 0, 0); chk("t3_rd1", int'(oitf_ret_rdidx), 7); chk("t3_p1", int'(oitf_ret_ptr), 1); tick();
        drive(0, 1, 0, 0, 0, 0); chk("t3_empty", int'(oitf_empty), 1); chk("t3_pw", int'(oitf_ret_ptr), 0); tick();
        drive(0, 0, 0, 0, 0, 0); chk("t3_empty_hold", int'(oitf_empty), 1); chk("t3_ptr_hold", int'(oitf_ret_ptr), 0); tick();

        // T4 wrap with alternating dispatch/retire
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, i + 1, 1, 0, 32'h200 + 4 * i); chk("t4_dis_ptr", int'(dis_ptr), i % 2); tick();
            drive(0, 1, 0, 0, 0, 0);
            chk("t4_pc", int'(oitf_ret_pc), 32'h200 + 4 * i); chk("t4_not_full", int'(oitf_full), 0); tick();
        end

        // T5 hazard detection
        rst_pulse();
        drive(1, 0, 3, 1, 0, 32'h300); tick();
        set_src(3, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); chk("t5_raw", int'(m_rs1), 1);
        dis_rs1fpu = 1; #1; chk("t5_raw_fpu", int'(m_rs1), 0);
        dis_rdidx = 5'd3; dis_rdwen = 1; #1; chk("t5_waw", int'(m_rd), 1);
        tick();
        rst_pulse();
        drive(1, 0, 3, 0, 0, 32'h304); tick();
        set_src(3, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); chk("t5_no_rdwen", int'(m_rs1), 0); tick();

        // T6 simultaneous dispatch/retire, then reset while full
        rst_pulse();
        drive(1, 0, 10, 1, 0, 32'h400); tick();
        drive(1, 1, 11, 1, 0, 32'h404); chk("t6_head", int'(oitf_ret_rdidx), 10); tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_cnt_empty", int'(oitf_empty), 0); chk("t6_cnt_full", int'(oitf_full), 0);
        chk("t6_new_head", int'(oitf_ret_rdidx), 11); chk("t6_head_ptr", int'(oitf_ret_ptr), 1); tick();
        drive(1, 0, 12, 1, 1, 32'h408); tick();
        set_src(11, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); chk("t6_full", int'(oitf_full), 1); chk("t6_pre_rst_raw", int'(m_rs1), 1);
        rst_pulse();

        // Random run against the queue model
        for (int i = 0; i < 5000; i++) begin
            set_src($urandom_range(0, 3), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3), 1'($urandom), 1'($urandom));
            drive(1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom), int'($urandom));
            tick();
            if (i % 997 == 500) rst_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
